// File: rtl/if_prefetch_unit.sv
// Instruction-fetch prefetcher: issues sequential word fetches and buffers in-order responses.
// Define IF_PREFETCH_STATS_EN to add saturating stall/flush counters.
module if_prefetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            req_valid_o,
  input  logic            req_ready_i,
  output logic [XLEN-1:0] req_addr_o,
  input  logic            rsp_valid_i,
  input  logic [XLEN-1:0] rsp_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_instr_o,
  output logic [XLEN-1:0] out_pc_o,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i
`ifdef IF_PREFETCH_STATS_EN
  ,
  output logic [31:0]     stall_cnt_o,
  output logic [15:0]     flush_cnt_o
`endif
);

  localparam int unsigned IdxW  = $clog2(DEPTH);
  localparam int unsigned PtrW  = IdxW + 1;
  localparam int unsigned DiscW = 8;
  localparam logic [PtrW-1:0] FullOcc = PtrW'(DEPTH);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0]  alloc_ptr_q, alloc_ptr_d;
  logic [PtrW-1:0]  fill_ptr_q, fill_ptr_d;
  logic [PtrW-1:0]  head_ptr_q, head_ptr_d;
  logic [DiscW-1:0] discard_q, discard_d;
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [XLEN-1:0]  hold_pc_q, hold_instr_q;
  logic [XLEN-1:0]  pc_mem_q    [DEPTH];
  logic [XLEN-1:0]  instr_mem_q [DEPTH];

  logic [PtrW-1:0]  occupancy;
  logic [PtrW-1:0]  in_flight;
  logic [IdxW-1:0]  alloc_idx, fill_idx, head_idx;
  logic             issue, fill, dequeue;
  logic             unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  assign alloc_idx = alloc_ptr_q[IdxW-1:0];
  assign fill_idx  = fill_ptr_q[IdxW-1:0];
  assign head_idx  = head_ptr_q[IdxW-1:0];
  assign occupancy = alloc_ptr_q - head_ptr_q;
  assign in_flight = alloc_ptr_q - fill_ptr_q;

  // Occupancy is judged before any same-cycle dequeue, so a full buffer never issues.
  assign req_valid_o = rst_n && (occupancy < FullOcc) && !redirect_i;
  assign out_valid_o = rst_n && filled_q[head_idx] && (occupancy != '0) && !redirect_i;
  assign req_addr_o  = fetch_pc_q;
  assign out_pc_o    = out_valid_o ? pc_mem_q[head_idx]    : hold_pc_q;
  assign out_instr_o = out_valid_o ? instr_mem_q[head_idx] : hold_instr_q;

  assign issue   = req_valid_o && req_ready_i;
  assign dequeue = out_valid_o && out_ready_i;
  assign fill    = rst_n && rsp_valid_i && !redirect_i && (discard_q == '0);

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    discard_d   = discard_q;
    filled_d    = filled_q;
    if (redirect_i) begin
      fetch_pc_d  = {redirect_pc_i[XLEN-1:2], 2'b00};
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_ptr_d  = '0;
      filled_d    = '0;
      // Everything issued but unfilled is now wrong-path; a response this cycle is one of them.
      discard_d   = discard_q + DiscW'(in_flight);
      if (rsp_valid_i && (discard_d != '0)) begin
        discard_d = discard_d - DiscW'(1);
      end
    end else begin
      if (issue) begin
        fetch_pc_d            = fetch_pc_q + XLEN'(4);
        alloc_ptr_d           = alloc_ptr_q + PtrW'(1);
        filled_d[alloc_idx]   = 1'b0;
      end
      if (rsp_valid_i) begin
        if (discard_q != '0) begin
          discard_d = discard_q - DiscW'(1);
        end else begin
          filled_d[fill_idx] = 1'b1;
          fill_ptr_d         = fill_ptr_q + PtrW'(1);
        end
      end
      if (dequeue) begin
        filled_d[head_idx] = 1'b0;
        head_ptr_d         = head_ptr_q + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q   <= RESET_PC;
      alloc_ptr_q  <= '0;
      fill_ptr_q   <= '0;
      head_ptr_q   <= '0;
      discard_q    <= '0;
      filled_q     <= '0;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      discard_q   <= discard_d;
      filled_q    <= filled_d;
      if (out_valid_o) begin
        hold_pc_q    <= pc_mem_q[head_idx];
        hold_instr_q <= instr_mem_q[head_idx];
      end
    end
  end

  // Payload storage needs no reset: the filled bits qualify every read.
  always_ff @(posedge clk) begin
    if (issue) begin
      pc_mem_q[alloc_idx] <= fetch_pc_q;
    end
    if (fill) begin
      instr_mem_q[fill_idx] <= rsp_data_i;
    end
  end

`ifdef IF_PREFETCH_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (out_ready_i && !out_valid_o && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (redirect_i && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Self-checking bench for if_prefetch_unit: directed sequences, a redirect table and random
// traffic against a queue-based reference model with an in-order latency memory.
module tb_if_prefetch_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        req_valid_o;
  logic        req_ready_i;
  logic [31:0] req_addr_o;
  logic        rsp_valid_i;
  logic [31:0] rsp_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_instr_o;
  logic [31:0] out_pc_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
`ifdef IF_PREFETCH_STATS_EN
  logic [31:0] stall_cnt_o;
  logic [15:0] flush_cnt_o;
`endif

  if_prefetch_unit #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_o   (req_valid_o),
    .req_ready_i   (req_ready_i),
    .req_addr_o    (req_addr_o),
    .rsp_valid_i   (rsp_valid_i),
    .rsp_data_i    (rsp_data_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_instr_o   (out_instr_o),
    .out_pc_o      (out_pc_o),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i)
`ifdef IF_PREFETCH_STATS_EN
    ,
    .stall_cnt_o   (stall_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Stimulus knobs read by step()
  bit          d_rst_n     = 1'b0;
  bit          d_req_ready = 1'b0;
  bit          d_out_ready = 1'b0;
  bit          d_redirect  = 1'b0;
  logic [31:0] d_redir_pc  = '0;
  int          d_lat       = 1;

  // Values sampled in the most recent step
  bit          s_req_valid, s_out_valid, s_hs;
  logic [31:0] s_req_addr, s_out_pc, s_out_instr;

  // Memory: in-order pending responses, at most one per cycle
  typedef struct {
    logic [31:0] data;
    int          due;
  } pend_t;
  pend_t pq[$];
  int    last_due = 0;

  // Reference model: the buffer as a queue of fetched slots
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          filled;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] m_fetch_pc   = '0;
  int          m_discard    = 0;
  logic [31:0] m_hold_pc    = '0;
  logic [31:0] m_hold_instr = '0;
  bit          m_known      = 1'b0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endfunction

  task automatic step();
    bit          rsp_now;
    bit          e_rv, e_ov;
    logic [31:0] e_pc, e_in;
    int          unf, due, j;
    rst_n         = d_rst_n;
    req_ready_i   = d_req_ready;
    out_ready_i   = d_out_ready;
    redirect_i    = d_redirect;
    redirect_pc_i = d_redir_pc;
    rsp_now       = (pq.size() > 0) && (pq[0].due <= cyc);
    rsp_valid_i   = rsp_now;
    rsp_data_i    = rsp_now ? pq[0].data : $urandom();
    #1;
    e_rv = d_rst_n && (mq.size() < DEPTH) && !d_redirect;
    e_ov = d_rst_n && (mq.size() > 0) && mq[0].filled && !d_redirect;
    e_pc = e_ov ? mq[0].pc    : m_hold_pc;
    e_in = e_ov ? mq[0].instr : m_hold_instr;
    s_req_valid = req_valid_o;
    s_req_addr  = req_addr_o;
    s_out_valid = out_valid_o;
    s_out_pc    = out_pc_o;
    s_out_instr = out_instr_o;
    s_hs        = d_rst_n && req_valid_o && req_ready_i;
    if (m_known) begin
      check("req_valid", 32'(req_valid_o), 32'(e_rv));
      check("req_addr", req_addr_o, m_fetch_pc);
      check("out_valid", 32'(out_valid_o), 32'(e_ov));
      check("out_pc", out_pc_o, e_pc);
      check("out_instr", out_instr_o, e_in);
    end
    // Environment: memory answers whatever the DUT actually issued
    if (s_hs) begin
      due = (cyc + d_lat > last_due + 1) ? cyc + d_lat : last_due + 1;
      last_due = due;
      pq.push_back('{data: mem_data(req_addr_o), due: due});
    end
    if (rsp_now) void'(pq.pop_front());
    // Reference model update
    if (!d_rst_n) begin
      mq.delete();
      m_fetch_pc   = RESET_PC;
      m_discard    = 0;
      m_hold_pc    = '0;
      m_hold_instr = '0;
      m_known      = 1'b1;
    end else if (d_redirect) begin
      unf = 0;
      foreach (mq[k]) if (!mq[k].filled) unf++;
      m_discard = m_discard + unf - (rsp_now ? 1 : 0);
      if (m_discard < 0) m_discard = 0;
      mq.delete();
      m_fetch_pc = d_redir_pc & 32'hFFFF_FFFC;
    end else begin
      if (rsp_now) begin
        if (m_discard > 0) begin
          m_discard--;
        end else begin
          j = -1;
          foreach (mq[k]) if (j < 0 && !mq[k].filled) j = k;
          if (j >= 0) begin
            mq[j].instr  = rsp_data_i;
            mq[j].filled = 1'b1;
          end
        end
      end
      if (e_rv && d_req_ready) begin
        mq.push_back('{pc: m_fetch_pc, instr: '0, filled: 1'b0});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
      if (e_ov) begin
        m_hold_pc    = mq[0].pc;
        m_hold_instr = mq[0].instr;
        if (d_out_ready) void'(mq.pop_front());
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Memory must be quiescent across reset, so its pending queue is dropped here.
  task automatic do_reset();
    pq.delete();
    last_due    = cyc;
    d_rst_n     = 1'b0;
    d_redirect  = 1'b0;
    d_req_ready = 1'b0;
    d_out_ready = 1'b0;
    step();
    step();
    d_rst_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] addr0;
    logic [31:0] addr1;
  } redir_vec_t;

  redir_vec_t  vt[5];
  logic [31:0] got[$];
  int          redir_cyc, first_cyc, hs_cnt;
  bit          seen;

  initial begin
    vt[0] = '{rpc: 32'h0000_0203, addr0: 32'h0000_0200, addr1: 32'h0000_0204};
    vt[1] = '{rpc: 32'hFFFF_FFFC, addr0: 32'hFFFF_FFFC, addr1: 32'h0000_0000};
    vt[2] = '{rpc: 32'hFFFF_FFFF, addr0: 32'hFFFF_FFFC, addr1: 32'h0000_0000};
    vt[3] = '{rpc: 32'h0000_1001, addr0: 32'h0000_1000, addr1: 32'h0000_1004};
    vt[4] = '{rpc: 32'h8000_0002, addr0: 32'h8000_0000, addr1: 32'h8000_0004};

    // Reset state
    do_reset();
    check("rst req_valid", 32'(s_req_valid), 32'd0);
    check("rst out_valid", 32'(s_out_valid), 32'd0);
    check("rst req_addr", s_req_addr, RESET_PC);
    check("rst out_pc", s_out_pc, 32'd0);
    check("rst out_instr", s_out_instr, 32'd0);

    // Streaming with 1-cycle memory: pcs 0,4,8,12 after two start-up cycles
    d_req_ready = 1'b1;
    d_out_ready = 1'b1;
    d_lat       = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i < 2) begin
        check("startup out_valid", 32'(s_out_valid), 32'd0);
      end else begin
        check("stream out_valid", 32'(s_out_valid), 32'd1);
        check("stream out_pc", s_out_pc, 32'(4 * (i - 2)));
        check("stream out_instr", s_out_instr, mem_data(32'(4 * (i - 2))));
      end
    end

    // Consumer stalled: exactly DEPTH requests, then drain in order
    do_reset();
    d_req_ready = 1'b1;
    d_out_ready = 1'b0;
    hs_cnt      = 0;
    got.delete();
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_hs) begin
        hs_cnt++;
        got.push_back(s_req_addr);
      end
    end
    check("stall req count", 32'(hs_cnt), 32'(DEPTH));
    for (int k = 0; k < 4; k++) begin
      check("stall req addr", (k < got.size()) ? got[k] : 32'hDEAD_BEEF, 32'(4 * k));
    end
    check("stall req_valid held low", 32'(s_req_valid), 32'd0);
    d_out_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_out_valid) begin
        got.push_back(s_out_pc);
        if (got.size() <= 4) check("drain instr", s_out_instr, mem_data(s_out_pc));
      end
    end
    for (int k = 0; k < 4; k++) begin
      check("drain pc", (k < got.size()) ? got[k] : 32'hDEAD_BEEF, 32'(4 * k));
    end

    // 3-cycle memory, 3 outstanding, redirect to 0x100: late responses are dropped
    do_reset();
    d_req_ready = 1'b1;
    d_out_ready = 1'b1;
    d_lat       = 3;
    repeat (3) step();
    d_redirect = 1'b1;
    d_redir_pc = 32'h0000_0100;
    redir_cyc  = cyc;
    step();
    check("redir out_valid", 32'(s_out_valid), 32'd0);
    check("redir req_valid", 32'(s_req_valid), 32'd0);
    d_redirect = 1'b0;
    seen       = 1'b0;
    first_cyc  = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (!seen) begin
        first_cyc = cyc;
        step();
        if (s_out_valid) seen = 1'b1;
      end
    end
    check("redir first seen", 32'(seen), 32'd1);
    check("redir first pc", s_out_pc, 32'h0000_0100);
    check("redir first instr", s_out_instr, mem_data(32'h0000_0100));
    check("redir latency", 32'(first_cyc - redir_cyc), 32'd5);

    // Redirect with a filled head, a same-cycle response and out_ready=1
    do_reset();
    d_req_ready = 1'b1;
    d_out_ready = 1'b0;
    d_lat       = 1;
    repeat (3) step();
    d_out_ready = 1'b1;
    d_redirect  = 1'b1;
    d_redir_pc  = 32'h0000_0040;
    step();
    check("redir+rsp out_valid", 32'(s_out_valid), 32'd0);
    d_redirect = 1'b0;
    seen       = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (s_out_valid) seen = 1'b1;
    end
    check("redir+rsp seen", 32'(seen), 32'd1);
    check("redir+rsp pc", s_out_pc, 32'h0000_0040);
    check("redir+rsp instr", s_out_instr, mem_data(32'h0000_0040));

    // Redirect alignment and address wrap table
    d_req_ready = 1'b1;
    d_out_ready = 1'b1;
    d_lat       = 1;
    for (int v = 0; v < 5; v++) begin
      d_redirect = 1'b1;
      d_redir_pc = vt[v].rpc;
      step();
      d_redirect = 1'b0;
      step();
      check("tbl req_valid", 32'(s_req_valid), 32'd1);
      check("tbl addr0", s_req_addr, vt[v].addr0);
      step();
      check("tbl addr1", s_req_addr, vt[v].addr1);
    end

    // Random traffic against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      d_req_ready = ($urandom_range(0, 3) != 0);
      d_out_ready = ($urandom_range(0, 3) != 0);
      d_redirect  = !d_redirect && ($urandom_range(0, 19) == 0);
      d_redir_pc  = $urandom();
      d_lat       = $urandom_range(1, 4);
      step();
    end
    d_redirect = 1'b0;

`ifdef IF_PREFETCH_STATS_EN
    do_reset();
    d_req_ready = 1'b0;
    d_out_ready = 1'b1;
    repeat (5) step();
    d_out_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      d_redirect = 1'b1;
      d_redir_pc = 32'h0000_0400;
      step();
      d_redirect = 1'b0;
      step();
    end
    check("stall_cnt", stall_cnt_o, 32'd5);
    check("flush_cnt", 32'(flush_cnt_o), 32'd2);
    do_reset();
    check("stall_cnt rst", stall_cnt_o, 32'd0);
    check("flush_cnt rst", 32'(flush_cnt_o), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
